fwd_scoreboard: RTL and testbench

- Parametrised successor to the combinational ALU/branch forwarding unit.
- Keeps a registered tag pipeline of in-flight destination registers and selects the youngest ready producer for each source operand.
- Generates the load-use stall and counts stall cycles.
- Sits between ID and EX; one instance serves NUM_SRC source operands: ALU A/B, store data and branch compare.

---
 rtl/fwd_scoreboard_if.sv | 35 +++
 rtl/fwd_scoreboard.sv | 81 ++++++++
 tb/tb_fwd_scoreboard.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fwd_scoreboard_if.sv
// ID/EX forwarding scoreboard bus: issue info, operand lookups, forwarded data and stall.
interface fwd_scoreboard_if #(
    parameter int XLEN    = 32,
    parameter int REGW    = 5,
    parameter int NUM_SRC = 2,
    parameter int DEPTH   = 3,
    parameter int CNTW    = 16
) ();
    logic                      adv;
    logic                      flush;
    logic                      id_valid;
    logic [REGW-1:0]           id_rd;
    logic                      id_rw;
    logic                      id_load;
    logic [NUM_SRC*REGW-1:0]   src_addr;
    logic [NUM_SRC-1:0]        src_en;
    logic [NUM_SRC*XLEN-1:0]   src_rf_data;
    logic [DEPTH*XLEN-1:0]     stage_result;
    logic [NUM_SRC*XLEN-1:0]   src_data;
    logic [NUM_SRC-1:0]        src_hit;
    logic                      stall;
    logic [CNTW-1:0]           stall_cnt;

    modport master (
        output adv, flush, id_valid, id_rd, id_rw, id_load,
        output src_addr, src_en, src_rf_data, stage_result,
        input  src_data, src_hit, stall, stall_cnt
    );

    modport slave (
        input  adv, flush, id_valid, id_rd, id_rw, id_load,
        input  src_addr, src_en, src_rf_data, stage_result,
        output src_data, src_hit, stall, stall_cnt
    );
endinterface

// File: rtl/fwd_scoreboard.sv
// Tracks in-flight destination registers after ID, forwards the youngest ready
// producer to each source operand and raises the load-use stall.
module fwd_scoreboard #(
    parameter int XLEN     = 32,
    parameter int REGW     = 5,
    parameter int NUM_SRC  = 2,
    parameter int DEPTH    = 3,
    parameter int LOAD_LAT = 2,
    parameter int CNTW     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    fwd_scoreboard_if.slave   bus
);

    logic [DEPTH-1:0]             ent_v;
    logic [DEPTH-1:0]             ent_ld;
    logic [DEPTH-1:0][REGW-1:0]   ent_rd;
    logic [CNTW-1:0]              stall_cnt_q;

    logic [NUM_SRC*XLEN-1:0]      src_data_c;
    logic [NUM_SRC-1:0]           src_hit_c;
    logic [NUM_SRC-1:0]           src_wait;
    logic                         stall_c;
    logic                         ent_in_v;

    // Walk oldest to youngest so the youngest match overwrites any older one,
    // including the case where a younger not-ready load hides an older ready result.
    always_comb begin
        src_data_c = bus.src_rf_data;
        src_hit_c  = '0;
        src_wait   = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            for (int i = DEPTH - 1; i >= 0; i--) begin
                if (bus.src_en[s] && (bus.src_addr[s*REGW +: REGW] != '0) &&
                    ent_v[i] && (ent_rd[i] != '0) &&
                    (ent_rd[i] == bus.src_addr[s*REGW +: REGW])) begin
                    if (!ent_ld[i] || (i >= LOAD_LAT)) begin
                        src_data_c[s*XLEN +: XLEN] = bus.stage_result[i*XLEN +: XLEN];
                        src_hit_c[s]               = 1'b1;
                        src_wait[s]                = 1'b0;
                    end else begin
                        src_data_c[s*XLEN +: XLEN] = bus.src_rf_data[s*XLEN +: XLEN];
                        src_hit_c[s]               = 1'b0;
                        src_wait[s]                = 1'b1;
                    end
                end
            end
        end
    end

    assign stall_c  = |src_wait;
    assign ent_in_v = bus.id_valid & bus.id_rw & (bus.id_rd != '0) & ~stall_c & ~bus.flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent_v       <= '0;
            ent_ld      <= '0;
            ent_rd      <= '0;
            stall_cnt_q <= '0;
        end else if (bus.adv) begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                ent_v[i]  <= ent_v[i-1];
                ent_ld[i] <= ent_ld[i-1];
                ent_rd[i] <= ent_rd[i-1];
            end
            ent_v[0]  <= ent_in_v;
            ent_ld[0] <= bus.id_load;
            ent_rd[0] <= bus.id_rd;
            if (stall_c && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNTW'(1);
            end
        end
    end

    assign bus.src_data  = src_data_c;
    assign bus.src_hit   = src_hit_c;
    assign bus.stall     = stall_c;
    assign bus.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed and randomized checks of fwd_scoreboard against an instruction-history model.
module tb_fwd_scoreboard;
    localparam int XLEN     = 32;
    localparam int REGW     = 5;
    localparam int NUM_SRC  = 2;
    localparam int DEPTH    = 3;
    localparam int LOAD_LAT = 2;
    localparam int CNTW     = 4;
    localparam int CNT_MAX  = (1 << CNTW) - 1;

    typedef struct packed {
        logic            v;
        logic [REGW-1:0] rd;
        logic            ld;
    } inst_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fwd_scoreboard_if #(.XLEN(XLEN), .REGW(REGW), .NUM_SRC(NUM_SRC), .DEPTH(DEPTH), .CNTW(CNTW)) sb_if ();

    fwd_scoreboard #(.XLEN(XLEN), .REGW(REGW), .NUM_SRC(NUM_SRC), .DEPTH(DEPTH),
                     .LOAD_LAT(LOAD_LAT), .CNTW(CNTW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sb_if)
    );

    // history of issued instructions, index 0 = most recent (in EX)
    inst_t pipe[$];
    int    model_cnt;
    logic  exp_stall;
    int    checks = 0;
    int    errors = 0;

    task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        pipe.delete();
        for (int i = 0; i < DEPTH; i++) pipe.push_back('0);
        model_cnt = 0;
        exp_stall = 1'b0;
    endtask

    // kind: 0 = no producer, 1 = ready producer at idx, 2 = producer not ready yet
    task automatic lookup(input logic en, input logic [REGW-1:0] a, output int kind, output int idx);
        kind = 0;
        idx  = 0;
        if (en && a != 0) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (pipe[i].v && pipe[i].rd == a) begin
                    idx  = i;
                    kind = (pipe[i].ld && i < LOAD_LAT) ? 2 : 1;
                    break;
                end
            end
        end
    endtask

    task automatic check_all();
        int   kind;
        int   idx;
        logic any_wait;
        any_wait = 1'b0;
        for (int s = 0; s < NUM_SRC; s++) begin
            lookup(sb_if.src_en[s], sb_if.src_addr[s*REGW +: REGW], kind, idx);
            if (kind == 0) begin
                chk($sformatf("src%0d_rf_pass", s), sb_if.src_data[s*XLEN +: XLEN], sb_if.src_rf_data[s*XLEN +: XLEN]);
                chk($sformatf("src%0d_nohit", s), 32'(sb_if.src_hit[s]), 32'd0);
            end else if (kind == 1) begin
                chk($sformatf("src%0d_fwd_e%0d", s, idx), sb_if.src_data[s*XLEN +: XLEN], sb_if.stage_result[idx*XLEN +: XLEN]);
                chk($sformatf("src%0d_hit", s), 32'(sb_if.src_hit[s]), 32'd1);
            end else begin
                any_wait = 1'b1;
            end
        end
        chk("stall", 32'(sb_if.stall), 32'(any_wait));
        chk("stall_cnt", 32'(sb_if.stall_cnt), 32'(model_cnt));
        exp_stall = any_wait;
    endtask

    task automatic eval();
        @(negedge clk);
        check_all();
    endtask

    task automatic adv_edge();
        inst_t n;
        @(posedge clk);
        if (rst_n && sb_if.adv) begin
            n.v  = sb_if.id_valid && sb_if.id_rw && (sb_if.id_rd != 0) && !exp_stall && !sb_if.flush;
            n.rd = sb_if.id_rd;
            n.ld = sb_if.id_load;
            pipe.push_front(n);
            void'(pipe.pop_back());
            if (exp_stall && model_cnt != CNT_MAX) model_cnt++;
        end
        #1;
    endtask

    task automatic tick();
        eval();
        adv_edge();
    endtask

    task automatic idle();
        sb_if.adv          = 1'b1;
        sb_if.flush        = 1'b0;
        sb_if.id_valid     = 1'b0;
        sb_if.id_rd        = '0;
        sb_if.id_rw        = 1'b0;
        sb_if.id_load      = 1'b0;
        sb_if.src_en       = '0;
        sb_if.src_addr     = '0;
        sb_if.src_rf_data  = {$urandom, $urandom};
        sb_if.stage_result = {$urandom, $urandom, $urandom};
    endtask

    task automatic issue(input logic [REGW-1:0] rd, input logic ld);
        idle();
        sb_if.id_valid = 1'b1;
        sb_if.id_rd    = rd;
        sb_if.id_rw    = 1'b1;
        sb_if.id_load  = ld;
    endtask

    task automatic set_src(input int s, input logic en, input logic [REGW-1:0] a);
        sb_if.src_en[s]               = en;
        sb_if.src_addr[s*REGW +: REGW] = a;
    endtask

    task automatic set_result(input int i, input logic [XLEN-1:0] d);
        sb_if.stage_result[i*XLEN +: XLEN] = d;
    endtask

    // Leaves the bench just after a rising edge with reset released.
    task automatic do_reset();
        rst_n = 1'b0;
        model_clear();
        #1;
        check_all();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        set_src(0, 1'b1, 5'd5);
        set_src(1, 1'b1, 5'd7);
        do_reset();
        set_src(0, 1'b1, 5'd5);
        set_src(1, 1'b1, 5'd7);
        tick();

        // ALU producer forwarded from EX
        issue(5'd5, 1'b0);
        tick();
        idle();
        set_src(0, 1'b1, 5'd5);
        set_result(0, 32'hDEADBEEF);
        eval();
        chk("alu_fwd_data", sb_if.src_data[XLEN-1:0], 32'hDEADBEEF);
        chk("alu_fwd_hit", 32'(sb_if.src_hit[0]), 32'd1);
        chk("alu_fwd_stall", 32'(sb_if.stall), 32'd0);
        adv_edge();

        // load-use: consumer meets the load at entry 1, one stall then WB forward
        do_reset();
        issue(5'd7, 1'b1);
        tick();
        idle();
        tick();
        issue(5'd8, 1'b0);
        set_src(1, 1'b1, 5'd7);
        eval();
        chk("lu_stall", 32'(sb_if.stall), 32'd1);
        adv_edge();
        set_result(2, 32'h12345678);
        eval();
        chk("lu_fwd_data", sb_if.src_data[XLEN +: XLEN], 32'h12345678);
        chk("lu_stall_drop", 32'(sb_if.stall), 32'd0);
        chk("lu_cnt", 32'(sb_if.stall_cnt), 32'd1);
        adv_edge();

        // adjacent load-use: stalls until the load reaches LOAD_LAT
        do_reset();
        issue(5'd7, 1'b1);
        tick();
        issue(5'd8, 1'b0);
        set_src(0, 1'b1, 5'd7);
        tick();
        tick();
        tick();

        // youngest producer wins; a younger pending load blocks an older result
        do_reset();
        issue(5'd3, 1'b0);
        tick();
        issue(5'd3, 1'b0);
        tick();
        idle();
        set_src(0, 1'b1, 5'd3);
        set_result(0, 32'h0000000A);
        set_result(1, 32'h0000000B);
        eval();
        chk("prio_young", sb_if.src_data[XLEN-1:0], 32'h0000000A);
        adv_edge();
        do_reset();
        issue(5'd3, 1'b0);
        tick();
        issue(5'd3, 1'b1);
        tick();
        idle();
        set_src(0, 1'b1, 5'd3);
        set_result(1, 32'h0000000B);
        eval();
        chk("prio_load_stall", 32'(sb_if.stall), 32'd1);
        adv_edge();

        // x0 destination, x0 source and disabled sources never match
        do_reset();
        issue(5'd0, 1'b0);
        tick();
        idle();
        set_src(0, 1'b1, 5'd0);
        set_src(1, 1'b1, 5'd0);
        tick();
        issue(5'd9, 1'b1);
        tick();
        idle();
        set_src(0, 1'b0, 5'd9);
        set_src(1, 1'b0, 5'd9);
        eval();
        chk("dis_stall", 32'(sb_if.stall), 32'd0);
        chk("dis_hit", 32'(sb_if.src_hit), 32'd0);
        adv_edge();

        // flush alone kills the ID instruction; flush with stall is one bubble
        do_reset();
        issue(5'd6, 1'b0);
        sb_if.flush = 1'b1;
        tick();
        idle();
        set_src(0, 1'b1, 5'd6);
        tick();
        issue(5'd4, 1'b1);
        tick();
        issue(5'd6, 1'b0);
        set_src(0, 1'b1, 5'd4);
        sb_if.flush = 1'b1;
        tick();
        sb_if.flush = 1'b0;
        tick();
        idle();
        set_src(0, 1'b1, 5'd4);
        set_src(1, 1'b1, 5'd6);
        tick();

        // freeze mid-stall
        do_reset();
        issue(5'd7, 1'b1);
        tick();
        idle();
        set_src(1, 1'b1, 5'd7);
        sb_if.adv = 1'b0;
        repeat (4) tick();
        chk("frz_cnt", 32'(sb_if.stall_cnt), 32'd0);
        sb_if.adv = 1'b1;
        repeat (3) tick();

        // saturation and async reset during a stall
        do_reset();
        repeat (10) begin
            issue(5'd7, 1'b1);
            tick();
            idle();
            set_src(0, 1'b1, 5'd7);
            tick();
            tick();
        end
        chk("sat_cnt", 32'(sb_if.stall_cnt), 32'(CNT_MAX));
        issue(5'd7, 1'b1);
        tick();
        idle();
        set_src(0, 1'b1, 5'd7);
        #1;
        chk("rst_pre_stall", 32'(sb_if.stall), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_stall", 32'(sb_if.stall), 32'd0);
        chk("rst_cnt", 32'(sb_if.stall_cnt), 32'd0);
        chk("rst_hit", 32'(sb_if.src_hit), 32'd0);
        model_clear();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // randomized traffic over a small register space
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 79) == 0) do_reset();
            sb_if.adv          = ($urandom_range(0, 9) != 0);
            sb_if.flush        = ($urandom_range(0, 9) == 0);
            sb_if.id_valid     = ($urandom_range(0, 3) != 0);
            sb_if.id_rw        = ($urandom_range(0, 3) != 0);
            sb_if.id_load      = ($urandom_range(0, 2) == 0);
            sb_if.id_rd        = REGW'($urandom_range(0, 7));
            sb_if.src_rf_data  = {$urandom, $urandom};
            sb_if.stage_result = {$urandom, $urandom, $urandom};
            for (int s = 0; s < NUM_SRC; s++) begin
                set_src(s, ($urandom_range(0, 3) != 0), REGW'($urandom_range(0, 7)));
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
